tcdm_strided_reader: RTL and testbench
======================================

Name: tcdm_strided_reader

Overview:
- TCDM initiator that reads a 2D strided region and emits the words, in order, on a valid/ready stream.
- Sits between accelerator datapath and the cluster TCDM port; the bench connects it to the TCDM slave memory model.
- Bounds outstanding requests with a credit scheme sized to an internal response FIFO, because TCDM responses cannot be back-pressured.

Parameters:
- FIFO_DEPTH, 4, response FIFO entries; this is also the maximum number of outstanding plus buffered words.
- CNT_W, 16, width of the word and line counters.
- DATA_W, 32, TCDM data width; fixed at 32, word address step is 4 bytes.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear; aborts the transfer
- start_i  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  32  byte address of the first word; word aligned
- len_i  in  CNT_W  words per line
- n_lines_i  in  CNT_W  number of lines
- stride_i  in  32  byte offset between line starts
- busy_o  out  1  high from the accepted start until done or flush completes
- done_o  out  1  one-cycle pulse at normal completion
- tcdm_req_o  out  1  request
- tcdm_gnt_i  in  1  grant
- tcdm_add_o  out  32  byte address
- tcdm_wen_o  out  1  1 = read; constant 1
- tcdm_be_o  out  4  constant 4'hF
- tcdm_data_o  out  32  constant 0
- tcdm_r_data_i  in  32  response data
- tcdm_r_valid_i  in  1  response valid
- stream_data_o  out  32  output word (FIFO head)
- stream_valid_o  out  1  FIFO not empty
- stream_ready_i  in  1  consumer ready

Behaviour:
- Reset values:
  - req_o=0, add_o=0, busy_o=0, done_o=0, stream_valid_o=0.
  - FIFO empty, all counters 0, state IDLE.
- IDLE:
  - On start_i, latch the configuration, set line_base=base_addr, word=0, line=0.
  - If len_i==0 or n_lines_i==0: go to DONE, no TCDM traffic.
  - Otherwise go to REQ; busy_o rises the cycle after start.
- REQ:
  - req_o=1 when credit is available, i.e. outstanding + fifo_count < FIFO_DEPTH. The credit is reserved when req first rises.
  - add_o = line_base + 4*word, modulo 2^32.
  - Once asserted, req_o and add_o are held stable until gnt; no retraction.
  - Request handshake completes on req&gnt; outstanding increments.
  - Advance word. When word == len-1: word=0, line_base += stride (mod 2^32), line++.
  - After the last word of the last line is granted, go to DRAIN with req_o=0 that cycle.
- Response path:
  - Responses are in order, latency ≥1 cycle.
  - tcdm_r_valid_i pushes r_data into the FIFO and decrements outstanding.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Grant and response in the same cycle leave outstanding unchanged.
  - The credit rule guarantees the FIFO never overflows. A push when full, or r_valid with outstanding==0, is a bench assertion error.
- Stream:
  - stream_valid_o = FIFO not empty.
  - Pop on valid&ready.
  - stream_data_o is stable while valid and not ready.
- DRAIN: when outstanding==0 and the FIFO is empty, go to DONE.
- DONE: done_o=1 for one cycle, busy_o=0 next cycle, return to IDLE.
- clear_i, any state, highest priority:
  - Flush the FIFO and drop req_o immediately.
  - If outstanding>0, go to FLUSH: busy_o stays 1, arriving responses are discarded, and FLUSH exits to IDLE at outstanding==0 with no done pulse.
  - If outstanding==0, go directly to IDLE.
- start_i outside IDLE is ignored.
- Asynchronous reset mid-transfer returns everything to reset values; late responses after reset are the system's responsibility.
- Throughput: one request per cycle with gnt=1, latency 1 cycle, and the consumer always ready.

Decomposition:
- Package tcdm_strided_reader_pkg:
  - state enum {IDLE, REQ, DRAIN, DONE, FLUSH}.
  - WORD_BYTES=4.
  - TCDM_BE_ALL=4'hF.
- Sub-module tcdm_reader_fifo:
  - Parameterised depth.
  - Synchronous flush.
  - Exposes count for the credit check.
  - Fall-through-free; data registered at the head.

Test Plan:
- Basic: base=0x100, len=4, n_lines=1, gnt=1, ready=1 → addresses 0x100, 0x104, 0x108, 0x10C on consecutive cycles; stream words equal memory[0x40..0x43]; done pulses once; busy low after.
- Strided: base=0x0, len=2, n_lines=3, stride=0x40 → addresses 0x0, 0x4, 0x40, 0x44, 0x80, 0x84 in order; 6 stream beats.
- Backpressure: len=16, ready=0 for 20 cycles → at most FIFO_DEPTH (4) grants before the stall; no overflow; releasing ready delivers all 16 words in order.
- Random stalls: PROB_STALL=0.5 on gnt, len=32 → req/add held stable while gnt=0; data sequence matches the golden model; exactly 32 reads counted.
- Zero length: len=0, n_lines=5 → no req ever; done pulses 2 cycles after start.
- Clear: clear_i with 3 words outstanding → req drops the same cycle; FIFO empties; no stream beats after clear; busy falls once outstanding reaches 0; no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/tcdm_strided_reader_pkg.sv
// Shared types and constants for the TCDM strided reader.
package tcdm_strided_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DRAIN,
    DONE,
    FLUSH
  } state_e;

  localparam int unsigned WORD_BYTES  = 4;
  localparam logic [3:0]  TCDM_BE_ALL = 4'hF;

endpackage

// File: rtl/tcdm_reader_fifo.sv
// Response FIFO for the strided reader: registered storage, head read from
// the array, synchronous flush, occupancy exported for credit accounting.
module tcdm_reader_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               pop_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               empty_o,
  output logic [COUNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [COUNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop  = pop_i && (r_count != '0);
  assign w_push = push_i && ((r_count != COUNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule

// File: rtl/tcdm_strided_reader.sv
// TCDM initiator reading a 2D strided region into a valid/ready stream,
// with outstanding requests bounded by credits sized to the response FIFO.
module tcdm_strided_reader
  import tcdm_strided_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [31:0]       base_addr_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [CNT_W-1:0]  n_lines_i,
  input  logic [31:0]       stride_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              tcdm_req_o,
  input  logic              tcdm_gnt_i,
  output logic [31:0]       tcdm_add_o,
  output logic              tcdm_wen_o,
  output logic [3:0]        tcdm_be_o,
  output logic [DATA_W-1:0] tcdm_data_o,
  input  logic [DATA_W-1:0] tcdm_r_data_i,
  input  logic              tcdm_r_valid_i,
  output logic [DATA_W-1:0] stream_data_o,
  output logic              stream_valid_o,
  input  logic              stream_ready_i
);

  localparam int unsigned OUT_W = $clog2(FIFO_DEPTH + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [31:0]        r_line_base;
  logic [31:0]        r_stride;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_n_lines;
  logic [CNT_W-1:0]   r_word;
  logic [CNT_W-1:0]   r_line;
  logic [OUT_W-1:0]   r_outst;
  logic               r_hold;
  logic               r_done;

  logic               w_start;
  logic               w_req;
  logic               w_grant;
  logic               w_credit;
  logic               w_last_word;
  logic               w_last_line;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_empty;
  logic [OUT_W-1:0]   w_fifo_count;
  logic [OUT_W:0]     w_used;
  logic [DATA_W-1:0]  w_fifo_data;

  assign w_used      = {1'b0, r_outst} + {1'b0, w_fifo_count};
  assign w_credit    = (w_used < (OUT_W + 1)'(FIFO_DEPTH));
  assign w_last_word = (r_word == r_len - CNT_W'(1));
  assign w_last_line = (r_line == r_n_lines - CNT_W'(1));
  assign w_start     = (r_state == IDLE) && start_i && !clear_i;
  assign w_grant     = w_req && tcdm_gnt_i;
  assign w_push      = tcdm_r_valid_i && (r_state != FLUSH) && !clear_i;
  assign w_pop       = stream_valid_o && stream_ready_i;

  // A raised request keeps its reserved credit (r_hold) until granted, so
  // address and request never retract even if occupancy changes meanwhile.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = (len_i == '0 || n_lines_i == '0) ? DONE : REQ;
      end
      REQ: begin
        w_req = r_hold || w_credit;
        if (w_req && tcdm_gnt_i && w_last_word && w_last_line) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_outst == '0 && w_fifo_empty) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      FLUSH: begin
        if (r_outst == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) begin
      w_req       = 1'b0;
      w_state_nxt = (r_outst != '0) ? FLUSH : IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_line_base <= '0;
      r_stride    <= '0;
      r_len       <= '0;
      r_n_lines   <= '0;
      r_word      <= '0;
      r_line      <= '0;
      r_outst     <= '0;
      r_hold      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_req && !tcdm_gnt_i;
      // done is registered off the DONE state, landing one cycle after it
      r_done  <= (r_state == DONE) && !clear_i;

      case ({w_grant, tcdm_r_valid_i})
        2'b10:   r_outst <= r_outst + OUT_W'(1);
        2'b01:   if (r_outst != '0) r_outst <= r_outst - OUT_W'(1);
        default: r_outst <= r_outst;
      endcase

      if (w_start) begin
        r_line_base <= base_addr_i;
        r_stride    <= stride_i;
        r_len       <= len_i;
        r_n_lines   <= n_lines_i;
        r_word      <= '0;
        r_line      <= '0;
      end else if (w_grant) begin
        if (w_last_word) begin
          r_word      <= '0;
          r_line_base <= r_line_base + r_stride;
          r_line      <= r_line + CNT_W'(1);
        end else begin
          r_word <= r_word + CNT_W'(1);
        end
      end
    end
  end

  tcdm_reader_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .DATA_W  (DATA_W),
    .COUNT_W (OUT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (w_push),
    .data_i  (tcdm_r_data_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign busy_o         = (r_state != IDLE);
  assign done_o         = r_done;
  assign tcdm_req_o     = w_req;
  assign tcdm_add_o     = r_line_base + (32'(r_word) * 32'(WORD_BYTES));
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = TCDM_BE_ALL;
  assign tcdm_data_o    = '0;
  assign stream_data_o  = w_fifo_data;
  assign stream_valid_o = !w_fifo_empty;

endmodule

// File: tb/tb_tcdm_strided_reader.sv
// Bench for tcdm_strided_reader: TCDM slave model with random grant/latency,
// random consumer, and an address/data reference built from the 2D rule.
module tb_tcdm_strided_reader;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] base;
    int unsigned len;
    int unsigned nl;
    logic [31:0] stride;
    int unsigned gnt_pct;
    int unsigned lat_max;
    int unsigned rdy_pct;
    int unsigned rdy_hold;
    int unsigned exp_beats;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n, clear, start;
  logic [31:0] base_addr, stride;
  logic [15:0] len, n_lines;
  logic        busy, done, req, gnt, wen, r_valid, s_valid, s_ready;
  logic [31:0] add, wdata, r_data, s_data;
  logic [3:0]  be;

  tcdm_strided_reader #(.FIFO_DEPTH(DEPTH), .CNT_W(16), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .base_addr_i(base_addr), .len_i(len), .n_lines_i(n_lines), .stride_i(stride),
    .busy_o(busy), .done_o(done),
    .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add), .tcdm_wen_o(wen),
    .tcdm_be_o(be), .tcdm_data_o(wdata), .tcdm_r_data_i(r_data),
    .tcdm_r_valid_i(r_valid), .stream_data_o(s_data),
    .stream_valid_o(s_valid), .stream_ready_i(s_ready)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0, checks = 0, test_id = 0;
  int unsigned cyc = 0;
  int unsigned gnt_pct = 100, lat_min = 1, lat_max = 1, rdy_pct = 100, rdy_hold_until = 0;
  int unsigned done_cnt, done_cyc, req_cycles, hold_viol, data_viol, max_inflight;
  int unsigned resp_cnt, last_resp_cyc;
  resp_t       resp_q[$];
  logic [31:0] grant_q[$];
  int unsigned grant_cyc_q[$];
  logic [31:0] beat_q[$];
  logic        hold_pending = 1'b0, data_pending = 1'b0;
  logic [31:0] hold_addr, pend_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (test %0d): got 0x%0h, expected 0x%0h", name, test_id, act, exp);
    end
  endtask

  // TCDM slave + stream consumer: drive at negedge, observe 3 ns later
  always @(negedge clk) begin
    if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
      r_valid = 1'b1;
      r_data  = resp_q[0].data;
      resp_q.delete(0);
      resp_cnt++;
      last_resp_cyc = cyc;
    end else begin
      r_valid = 1'b0;
      r_data  = $urandom;
    end
    gnt     = ($urandom_range(99) < gnt_pct);
    s_ready = (cyc >= rdy_hold_until) && ($urandom_range(99) < rdy_pct);
    #3;
    if (hold_pending && !clear && (!req || add !== hold_addr)) hold_viol++;
    if (data_pending && !clear && (!s_valid || s_data !== pend_data)) data_viol++;
    if (req) req_cycles++;
    if (req && gnt) begin
      grant_q.push_back(add);
      grant_cyc_q.push_back(cyc);
      resp_q.push_back('{data: mem_word(add), due: cyc + $urandom_range(lat_max, lat_min)});
    end
    if (s_valid && s_ready) beat_q.push_back(s_data);
    if (done) begin done_cnt++; done_cyc = cyc; end
    hold_pending = req && !gnt;
    hold_addr    = add;
    data_pending = s_valid && !s_ready;
    pend_data    = s_data;
    if (grant_q.size() > beat_q.size() && grant_q.size() - beat_q.size() > max_inflight)
      max_inflight = grant_q.size() - beat_q.size();
    cyc++;
  end

  task automatic clear_stats();
    grant_q.delete(); grant_cyc_q.delete(); beat_q.delete();
    done_cnt = 0; req_cycles = 0; hold_viol = 0; data_viol = 0;
    max_inflight = 0; resp_cnt = 0; last_resp_cyc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    resp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_xfer(input vec_t v);
    logic [31:0] exp_a[$];
    int unsigned t0, waited, bad_a, bad_d, g_hold, tot;
    tot = v.len * v.nl;
    for (int unsigned l = 0; l < v.nl; l++)
      for (int unsigned w = 0; w < v.len; w++)
        exp_a.push_back(v.base + l * v.stride + w * 4);
    @(negedge clk);
    gnt_pct = v.gnt_pct; lat_min = 1; lat_max = v.lat_max; rdy_pct = v.rdy_pct;
    clear_stats();
    base_addr = v.base; len = 16'(v.len); n_lines = 16'(v.nl); stride = v.stride;
    rdy_hold_until = cyc + 1 + v.rdy_hold;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    g_hold = 0;
    while (done_cnt == 0 && waited < 4000) begin
      if (cyc == t0 + v.rdy_hold) g_hold = grant_q.size();
      @(negedge clk);
      waited++;
    end
    check("done_seen", waited < 4000, 1'b1);
    if (waited >= 4000) begin
      do_reset();
      return;
    end
    #3 check("busy_after_done", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("n_grants", grant_q.size(), tot);
    check("n_beats", beat_q.size(), v.exp_beats);
    bad_a = 0;
    bad_d = 0;
    for (int i = 0; i < grant_q.size() && i < exp_a.size(); i++)
      if (grant_q[i] !== exp_a[i]) bad_a++;
    for (int i = 0; i < beat_q.size() && i < exp_a.size(); i++)
      if (beat_q[i] !== mem_word(exp_a[i])) bad_d++;
    check("addr_seq_mismatches", bad_a, 0);
    check("data_seq_mismatches", bad_d, 0);
    check("req_add_hold_viol", hold_viol, 0);
    check("stream_hold_viol", data_viol, 0);
    check("inflight_le_depth", max_inflight <= DEPTH, 1'b1);
    if (v.rdy_hold > 0) check("bp_grants_le_depth", g_hold <= DEPTH, 1'b1);
    if (tot == 0) begin
      check("zero_done_delay", done_cyc - t0, 2);
      check("zero_no_req", req_cycles, 0);
    end else if (v.gnt_pct == 100 && v.lat_max == 1 && v.rdy_pct == 100 && v.rdy_hold == 0) begin
      check("first_grant_cyc", grant_cyc_q[0] - t0, 1);
      check("grant_span", grant_cyc_q[grant_cyc_q.size() - 1] - grant_cyc_q[0], tot - 1);
    end
  endtask

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    vec_t v;
    tbl[0] = '{32'h0000_0100,  4, 1, 32'h0,         100, 1, 100,  0,  4};
    tbl[1] = '{32'h0000_0000,  2, 3, 32'h40,        100, 1, 100,  0,  6};
    tbl[2] = '{32'h0000_2000, 16, 1, 32'h0,         100, 1, 100, 20, 16};
    tbl[3] = '{32'h0000_0400, 32, 1, 32'h0,          50, 3,  70,  0, 32};
    tbl[4] = '{32'h0000_0000,  0, 5, 32'h10,        100, 1, 100,  0,  0};
    tbl[5] = '{32'h0000_0080,  3, 0, 32'h10,        100, 1, 100,  0,  0};
    tbl[6] = '{32'hFFFF_FFF8,  3, 2, 32'h100,       100, 2, 100,  0,  6};
    tbl[7] = '{32'h0000_1000,  2, 3, 32'hFFFF_FFC0,  60, 4,  50,  0,  6};

    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    base_addr = '0; len = '0; n_lines = '0; stride = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", req, 1'b0);
    check("rst_add", add, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_svalid", s_valid, 1'b0);
    check("wen_const", wen, 1'b1);
    check("be_const", be, 4'hF);
    check("wdata_const", wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      test_id = i;
      run_xfer(tbl[i]);
    end

    // clear with three reads outstanding (fixed long latency)
    test_id = 100;
    @(negedge clk);
    gnt_pct = 100; lat_min = 6; lat_max = 6; rdy_pct = 100; rdy_hold_until = 0;
    clear_stats();
    base_addr = 32'h3000; len = 16'd16; n_lines = 16'd1; stride = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (grant_q.size() < 3 && w < 50) begin @(negedge clk); w++; end
    check("clr_grants_before", grant_q.size(), 3);
    clear = 1'b1;
    #3 check("clr_req_drop", req, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    w = 0;
    while (busy && w < 100) begin @(negedge clk); w++; end
    check("clr_busy_falls", w < 100, 1'b1);
    check("clr_resp_all_seen", resp_cnt, 3);
    check("clr_busy_after_last_resp", cyc > last_resp_cyc, 1'b1);
    repeat (3) @(negedge clk);
    check("clr_no_beats", beat_q.size(), 0);
    check("clr_no_done", done_cnt, 0);
    check("clr_svalid", s_valid, 1'b0);
    check("clr_grants_after", grant_q.size(), 3);
    lat_min = 1;
    test_id = 101;
    run_xfer(tbl[0]);

    // asynchronous reset mid-transfer
    test_id = 200;
    @(negedge clk);
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    base_addr = 32'h500; len = 16'd8; n_lines = 16'd1; stride = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    resp_q.delete();
    #1;
    check("arst_req", req, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_add", add, 32'h0);
    check("arst_svalid", s_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      test_id = 300 + i;
      v.base      = $urandom & 32'hFFFF_FFFC;
      v.len       = $urandom_range(8, 1);
      v.nl        = $urandom_range(4, 1);
      v.stride    = 32'($urandom_range(1023)) << 2;
      if ($urandom_range(1) == 1) v.stride = -v.stride;
      v.gnt_pct   = $urandom_range(100, 30);
      v.lat_max   = $urandom_range(4, 1);
      v.rdy_pct   = $urandom_range(100, 40);
      v.rdy_hold  = 0;
      v.exp_beats = v.len * v.nl;
      run_xfer(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
